imem_responder: RTL and testbench

Memory-side responder for the instruction-fetch request interface that the compressed-icache controller drives. It services one word read per handshake from a word-addressed instruction array after a parameterised latency, returning data with a one-cycle ready pulse. A backdoor load port fills the array before or during a run. A response counter supports miss-traffic accounting in cache benches and on the synthesised test harness.

---
 rtl/imem_responder.sv | 140 ++++++++++++++
 tb/tb_imem_responder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// imem_responder: memory-side responder for the instruction-fetch request interface.
// Services one word read per valid episode from a word-addressed array after LATENCY
// wait cycles, returning the word alongside a single-cycle ready pulse. A backdoor
// load port writes the array in any state; a wrapping counter tallies responses.
//
// Ports:
//   clk            sole clock, rising edge
//   reset          asynchronous active-high reset (array contents survive)
//   mem_req_valid  read request, held until mem_req_ready is seen
//   mem_req_addr   byte address, bits [1:0] ignored
//   mem_req_ready  one-cycle response pulse
//   mem_req_rdata  response word, 0 whenever mem_req_ready is low
//   load_valid     backdoor write strobe
//   load_addr      backdoor word index
//   load_data      backdoor write data
//   resp_count     completed responses, wraps modulo 2^32
//   busy           high while a request is in flight (WAIT or RESP)
module imem_responder #(
   parameter int unsigned MEM_WORDS = 1024,
   parameter int unsigned LATENCY   = 3,
   parameter logic [31:0] OOR_WORD  = 32'h0000_0013
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         mem_req_valid,
   input  logic [31:0]                  mem_req_addr,
   output logic                         mem_req_ready,
   output logic [31:0]                  mem_req_rdata,
   input  logic                         load_valid,
   input  logic [$clog2(MEM_WORDS)-1:0] load_addr,
   input  logic [31:0]                  load_data,
   output logic [31:0]                  resp_count,
   output logic                         busy
);

   localparam int unsigned AW = $clog2(MEM_WORDS);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e        state_q;
   logic [3:0]    cnt_q;
   logic [AW-1:0] idx_q;
   logic          oor_q;

   logic [31:0]   mem [MEM_WORDS];

   logic [AW-1:0] rd_idx;
   logic          rd_oor;
   logic [31:0]   rd_word;

   // Byte-offset bits carry no information for word reads.
   logic          unused_addr_bits;
   assign unused_addr_bits = ^mem_req_addr[1:0];

   // Backdoor port: independent of the FSM and of reset.
   always_ff @(posedge clk) begin
      if (load_valid) begin
         mem[load_addr] <= load_data;
      end
   end

   // With zero latency RESP is entered straight from IDLE, before the address has
   // been latched, so the read index comes from the live address in IDLE.
   always_comb begin
      rd_idx  = idx_q;
      rd_oor  = oor_q;
      rd_word = '0;
      if (state_q == StIdle) begin
         rd_idx = mem_req_addr[AW+1:2];
         rd_oor = |mem_req_addr[31:AW+2];
      end
      if (rd_oor) begin
         rd_word = OOR_WORD;
      end else if (load_valid && (load_addr == rd_idx)) begin
         // Write-through so a same-edge backdoor write is not missed.
         rd_word = load_data;
      end else begin
         rd_word = mem[rd_idx];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         idx_q         <= '0;
         oor_q         <= 1'b0;
         mem_req_ready <= 1'b0;
         mem_req_rdata <= '0;
         resp_count    <= '0;
         busy          <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (mem_req_valid) begin
                  idx_q <= mem_req_addr[AW+1:2];
                  oor_q <= |mem_req_addr[31:AW+2];
                  cnt_q <= 4'(LATENCY);
                  busy  <= 1'b1;
                  if (LATENCY == 0) begin
                     state_q       <= StResp;
                     mem_req_ready <= 1'b1;
                     mem_req_rdata <= rd_word;
                  end else begin
                     state_q <= StWait;
                  end
               end
            end
            StWait: begin
               cnt_q <= cnt_q - 4'd1;
               if (!mem_req_valid) begin
                  // Requester gave up: drop the request silently.
                  state_q <= StIdle;
                  busy    <= 1'b0;
                  cnt_q   <= '0;
               end else if (cnt_q == 4'd1) begin
                  state_q       <= StResp;
                  mem_req_ready <= 1'b1;
                  mem_req_rdata <= rd_word;
               end
            end
            StResp: begin
               // Never accepts here: valid is still high from the episode just served.
               state_q       <= StIdle;
               mem_req_ready <= 1'b0;
               mem_req_rdata <= '0;
               resp_count    <= resp_count + 32'd1;
               busy          <= 1'b0;
            end
            default: begin
               state_q       <= StIdle;
               mem_req_ready <= 1'b0;
               mem_req_rdata <= '0;
               busy          <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: two instances share clock, reset and backdoor port.
//   dut_a: MEM_WORDS=256,  LATENCY=3
//   dut_b: MEM_WORDS=1024, LATENCY=0
// Expected words come from a behavioural memory image updated on every load.
module tb_imem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load_valid = 1'b0;
   logic [9:0]  load_addr = '0;
   logic [31:0] load_data = '0;

   logic        a_valid = 1'b0, b_valid = 1'b0;
   logic [31:0] a_addr = '0, b_addr = '0;
   logic        a_ready, b_ready, a_busy, b_busy;
   logic [31:0] a_rdata, b_rdata, a_count, b_count;

   int          n_pass = 0;
   int          n_chk = 0;
   int          cyc = 0;
   int          exp_a = 0;
   int          exp_b = 0;
   logic [31:0] model [1024];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   imem_responder #(.MEM_WORDS(256), .LATENCY(3), .OOR_WORD(32'h0000_0013)) dut_a (
      .clk(clk), .reset(rst), .mem_req_valid(a_valid), .mem_req_addr(a_addr),
      .mem_req_ready(a_ready), .mem_req_rdata(a_rdata), .load_valid(load_valid),
      .load_addr(load_addr[7:0]), .load_data(load_data), .resp_count(a_count), .busy(a_busy)
   );

   imem_responder #(.MEM_WORDS(1024), .LATENCY(0), .OOR_WORD(32'h0000_0013)) dut_b (
      .clk(clk), .reset(rst), .mem_req_valid(b_valid), .mem_req_addr(b_addr),
      .mem_req_ready(b_ready), .mem_req_rdata(b_rdata), .load_valid(load_valid),
      .load_addr(load_addr), .load_data(load_data), .resp_count(b_count), .busy(b_busy)
   );

   function automatic logic rdy(input int w);
      return (w == 0) ? a_ready : b_ready;
   endfunction

   function automatic logic [31:0] rdat(input int w);
      return (w == 0) ? a_rdata : b_rdata;
   endfunction

   function automatic logic [31:0] cnt_of(input int w);
      return (w == 0) ? a_count : b_count;
   endfunction

   // Addresses at or past the array size read as a NOP; otherwise the image word.
   function automatic logic [31:0] ref_word(input int w, input logic [31:0] addr);
      longint words;
      words = (w == 0) ? 256 : 1024;
      if (longint'(addr) >= words * 4) return 32'h0000_0013;
      return model[int'(addr >> 2)];
   endfunction

   task automatic drive(input int w, input logic v, input logic [31:0] ad);
      if (w == 0) begin a_valid = v; a_addr = ad; end
      else begin b_valid = v; b_addr = ad; end
   endtask

   task automatic do_load(input int idx, input logic [31:0] d);
      load_valid = 1'b1; load_addr = 10'(idx); load_data = d; model[idx] = d;
      @(posedge clk); #1;
      load_valid = 1'b0;
   endtask

   // Controller-style requester: hold valid until ready, keep it one more cycle,
   // drop it, then leave one idle cycle. lat = edges from raising valid to seeing ready.
   // clean goes low if rdata is nonzero without ready, or ready lasts over one cycle.
   task automatic req(input int w, input logic [31:0] addr, input bit coll,
                      input logic [31:0] cdata, output bit got, output int lat,
                      output logic [31:0] data, output bit clean, output int at);
      int lt;
      lt = (w == 0) ? 3 : 0;
      got = 1'b0; lat = 0; data = '0; clean = 1'b1; at = 0;
      drive(w, 1'b1, addr);
      for (int i = 1; i <= 40 && !got; i++) begin
         @(posedge clk); #1;
         if (coll && i == lt + 1) load_valid = 1'b0;
         if (rdy(w)) begin got = 1'b1; lat = i; data = rdat(w); at = cyc; end
         else if (rdat(w) !== 32'h0) clean = 1'b0;
         if (coll && i == lt) begin
            load_valid = 1'b1; load_addr = 10'(addr >> 2); load_data = cdata;
            model[int'(addr >> 2)] = cdata;
         end
      end
      load_valid = 1'b0;
      if (got) begin
         @(posedge clk); #1;
         if (rdy(w) !== 1'b0 || rdat(w) !== 32'h0) clean = 1'b0;
      end
      drive(w, 1'b0, addr);
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_chk++;
      if ({a_ready, a_busy, a_rdata, a_count} !== 66'h0)
         $display("FAIL reset_a: got rdy=%0b busy=%0b rdata=%h cnt=%0d want all 0",
                  a_ready, a_busy, a_rdata, a_count);
      else n_pass++;
      n_chk++;
      if ({b_ready, b_busy, b_rdata, b_count} !== 66'h0)
         $display("FAIL reset_b: got rdy=%0b busy=%0b rdata=%h cnt=%0d want all 0",
                  b_ready, b_busy, b_rdata, b_count);
      else n_pass++;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic preload();
      for (int i = 0; i < 256; i++) do_load(i, $urandom);
   endtask

   task automatic test_basic();
      bit got, clean; int lat, at; logic [31:0] d;
      do_load(5, 32'hDEAD_BEEF);
      req(0, 32'h14, 1'b0, '0, got, lat, d, clean, at);
      exp_a++;
      n_chk++; if (got !== 1'b1) $display("FAIL basic_got: got %0b want 1", got); else n_pass++;
      n_chk++; if (lat != 4) $display("FAIL basic_lat: got %0d want 4", lat); else n_pass++;
      n_chk++; if (d !== 32'hDEAD_BEEF) $display("FAIL basic_data: got %h want deadbeef", d);
      else n_pass++;
      n_chk++; if (clean !== 1'b1) $display("FAIL basic_clean: got %0b want 1", clean);
      else n_pass++;
      n_chk++; if (a_count !== 32'(exp_a)) $display("FAIL basic_cnt: got %0d want %0d", a_count, exp_a);
      else n_pass++;
   endtask

   task automatic test_burst();
      bit got, clean; int lat, at, prev; logic [31:0] d, ad;
      for (int j = 0; j < 4; j++) do_load(16 + j, 32'hB000_0000 + 32'($urandom_range(65535, 0)));
      prev = 0;
      for (int j = 0; j < 4; j++) begin
         ad = 32'h40 + 32'(4 * j);
         req(1, ad, 1'b0, '0, got, lat, d, clean, at);
         exp_b++;
         n_chk++; if (got !== 1'b1 || lat != 1)
            $display("FAIL burst_lat%0d: got got=%0b lat=%0d want got=1 lat=1", j, got, lat);
         else n_pass++;
         n_chk++; if (d !== ref_word(1, ad))
            $display("FAIL burst_data%0d: got %h want %h", j, d, ref_word(1, ad));
         else n_pass++;
         n_chk++; if (clean !== 1'b1) $display("FAIL burst_clean%0d: got %0b want 1", j, clean);
         else n_pass++;
         if (j > 0) begin
            n_chk++; if (at - prev != 3)
               $display("FAIL burst_period%0d: got %0d want 3", j, at - prev);
            else n_pass++;
         end
         prev = at;
      end
      n_chk++; if (b_count !== 32'(exp_b)) $display("FAIL burst_cnt: got %0d want %0d", b_count, exp_b);
      else n_pass++;
   endtask

   task automatic test_oor();
      bit got, clean; int lat, at; logic [31:0] d;
      req(0, 32'h0000_0400, 1'b0, '0, got, lat, d, clean, at);
      exp_a++;
      n_chk++; if (got !== 1'b1 || d !== 32'h0000_0013)
         $display("FAIL oor_a: got got=%0b data=%h want got=1 data=00000013", got, d);
      else n_pass++;
      req(0, 32'h0000_03FC, 1'b0, '0, got, lat, d, clean, at);
      exp_a++;
      n_chk++; if (d !== model[255]) $display("FAIL oor_edge_a: got %h want %h", d, model[255]);
      else n_pass++;
      req(1, 32'h0000_1000, 1'b0, '0, got, lat, d, clean, at);
      exp_b++;
      n_chk++; if (got !== 1'b1 || d !== 32'h0000_0013)
         $display("FAIL oor_b: got got=%0b data=%h want got=1 data=00000013", got, d);
      else n_pass++;
   endtask

   task automatic test_abort();
      bit got, clean, seen; int lat, at; logic [31:0] d;
      drive(0, 1'b1, 32'h20);
      @(posedge clk); #1;
      n_chk++; if (a_busy !== 1'b1) $display("FAIL abort_busy: got %0b want 1", a_busy);
      else n_pass++;
      @(posedge clk); #1;
      drive(0, 1'b0, 32'h20);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (a_ready !== 1'b0) seen = 1'b1;
      end
      n_chk++; if (seen !== 1'b0) $display("FAIL abort_ready: got pulse=%0b want 0", seen);
      else n_pass++;
      n_chk++; if (a_busy !== 1'b0) $display("FAIL abort_idle: got busy=%0b want 0", a_busy);
      else n_pass++;
      n_chk++; if (a_count !== 32'(exp_a)) $display("FAIL abort_cnt: got %0d want %0d", a_count, exp_a);
      else n_pass++;
      req(0, 32'h20, 1'b0, '0, got, lat, d, clean, at);
      exp_a++;
      n_chk++; if (got !== 1'b1 || lat != 4 || d !== model[8] || clean !== 1'b1)
         $display("FAIL abort_next: got got=%0b lat=%0d data=%h want got=1 lat=4 data=%h",
                  got, lat, d, model[8]);
      else n_pass++;
   endtask

   task automatic test_collision();
      bit got, clean; int lat, at; logic [31:0] d;
      req(0, 32'h30, 1'b1, 32'h1234_5678, got, lat, d, clean, at);
      exp_a++;
      n_chk++; if (got !== 1'b1 || lat != 4 || d !== 32'h1234_5678)
         $display("FAIL collision: got got=%0b lat=%0d data=%h want got=1 lat=4 data=12345678",
                  got, lat, d);
      else n_pass++;
      req(1, 32'h30, 1'b0, '0, got, lat, d, clean, at);
      exp_b++;
      n_chk++; if (d !== 32'h1234_5678) $display("FAIL collision_stored: got %h want 12345678", d);
      else n_pass++;
   endtask

   task automatic test_reset_mid_wait();
      bit got, clean; int lat, at; logic [31:0] d;
      do_load(7, 32'hCAFE_F00D);
      drive(0, 1'b1, 32'h1C);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      exp_a = 0; exp_b = 0;
      n_chk++; if (a_ready !== 1'b0 || a_busy !== 1'b0 || a_count !== 32'h0)
         $display("FAIL rst_wait: got rdy=%0b busy=%0b cnt=%0d want 0 0 0", a_ready, a_busy, a_count);
      else n_pass++;
      n_chk++; if (b_count !== 32'h0) $display("FAIL rst_wait_b: got cnt=%0d want 0", b_count);
      else n_pass++;
      drive(0, 1'b0, 32'h1C);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      req(0, 32'h1C, 1'b0, '0, got, lat, d, clean, at);
      exp_a++;
      n_chk++; if (got !== 1'b1 || d !== 32'hCAFE_F00D || clean !== 1'b1)
         $display("FAIL rst_preserve: got got=%0b data=%h want got=1 data=cafef00d", got, d);
      else n_pass++;
      n_chk++; if (a_count !== 32'(exp_a)) $display("FAIL rst_cnt: got %0d want %0d", a_count, exp_a);
      else n_pass++;
   endtask

   task automatic test_random();
      bit got, clean; int lat, at, w; logic [31:0] d, ad;
      for (int n = 0; n < 40; n++) begin
         w = int'($urandom_range(1, 0));
         if ($urandom_range(9, 0) < 3) do_load(int'($urandom_range(255, 0)), $urandom);
         if ($urandom_range(2, 0) != 2) ad = 32'($urandom_range(255, 0)) * 4 + 32'($urandom_range(3, 0));
         else begin ad = $urandom; if (ad < 32'h1000) ad = ad | 32'h1000; end
         req(w, ad, 1'b0, '0, got, lat, d, clean, at);
         if (w == 0) exp_a++; else exp_b++;
         n_chk++; if (got !== 1'b1 || lat != ((w == 0) ? 4 : 1) || clean !== 1'b1)
            $display("FAIL rand%0d_hs: got got=%0b lat=%0d clean=%0b want 1 %0d 1",
                     n, got, lat, clean, (w == 0) ? 4 : 1);
         else n_pass++;
         n_chk++; if (d !== ref_word(w, ad))
            $display("FAIL rand%0d_data: addr %h got %h want %h", n, ad, d, ref_word(w, ad));
         else n_pass++;
         n_chk++; if (cnt_of(w) !== 32'((w == 0) ? exp_a : exp_b))
            $display("FAIL rand%0d_cnt: got %0d want %0d", n, cnt_of(w), (w == 0) ? exp_a : exp_b);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      preload();
      test_basic();
      test_burst();
      test_oor();
      test_abort();
      test_collision();
      test_reset_mid_wait();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
